// File: rtl/approx_pkg.sv
// Shared types and sizing helpers for the approximate sequential multiplier.
package approx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // Width of the approximation-level field: must represent 0..2*width inclusive.
  function automatic int lvl_width(input int width);
    return $clog2(2 * width) + 1;
  endfunction

endpackage

// File: rtl/rca_adder.sv
// Ripple-carry adder built from a half-adder cell at bit 0 and full-adder cells above it.
module HAX1 (
  input  logic a,
  input  logic b,
  output logic s,
  output logic co
);
  assign s  = a ^ b;
  assign co = a & b;
endmodule

module FAX1 (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module rca_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W-1:0] carry;

  HAX1 u_ha0 (.a(x[0]), .b(y[0]), .s(sum[0]), .co(carry[0]));

  for (genvar i = 1; i < W; i++) begin : g_fa
    FAX1 u_fa (.a(x[i]), .b(y[i]), .ci(carry[i-1]), .s(sum[i]), .co(carry[i]));
  end

  assign cout = carry[W-1];
endmodule

// File: rtl/approx_mul_seq.sv
// Sequential shift-add multiplier with low-column truncation of every partial product.
// Optional macro APPROX_EARLY_TERM_EN finishes as soon as the remaining multiplier bits are zero.
module approx_mul_seq
  import approx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LVL_W = lvl_width(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [LVL_W-1:0]   approx_lvl,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH);

  state_t             state;
  logic [PW-1:0]      a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [LVL_W-1:0]   lvl_reg;
  logic [PW-1:0]      acc;
  logic [CNT_W-1:0]   cnt;

  logic [PW-1:0]      col_mask;
  logic [PW-1:0]      addend;
  logic [PW-1:0]      sum;
  logic               sum_cout;
  logic               last_iter;

  // Columns below the level are dropped; a level covering the whole product drops everything.
  assign col_mask = (lvl_reg >= LVL_W'(PW)) ? '0 : ({PW{1'b1}} << lvl_reg);
  assign addend   = b_reg[0] ? (a_reg & col_mask) : '0;

  rca_adder #(.W(PW)) u_adder (
    .x    (acc),
    .y    (addend),
    .sum  (sum),
    .cout (sum_cout)
  );

`ifdef APPROX_EARLY_TERM_EN
  assign last_iter = (cnt == CNT_W'(WIDTH - 1)) || ((b_reg >> 1) == '0);
`else
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
`endif

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      lvl_reg   <= '0;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      product   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= PW'(a);
            b_reg   <= b;
            lvl_reg <= approx_lvl;
            acc     <= '0;
            cnt     <= '0;
`ifdef APPROX_EARLY_TERM_EN
            if (b == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              product   <= '0;
            end else begin
              state <= CALC;
            end
`else
            state <= CALC;
`endif
          end
        end
        CALC: begin
          acc   <= sum;
          a_reg <= a_reg << 1;
          b_reg <= b_reg >> 1;
          cnt   <= cnt + 1'b1;
          if (last_iter) begin
            state     <= DONE;
            out_valid <= 1'b1;
            product   <= sum;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            product   <= '0;
          end
        end
        default: state <= IDLE;
      endcase

      // The truncated sum is bounded by the exact product, so the adder never carries out.
      if (state == CALC) begin
        assert (!sum_cout) else $error("approx_mul_seq: accumulator overflow");
      end
    end
  end

endmodule

// File: tb/tb_approx_mul_seq.sv
// Self-checking bench for approx_mul_seq (WIDTH=8): vector table, hand sequences, random vs model.
module tb_approx_mul_seq;

  localparam int WIDTH = 8;
  localparam int LVL_W = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [LVL_W-1:0]   approx_lvl;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  int n_checks = 0;
  int n_errors = 0;

  approx_mul_seq #(.WIDTH(WIDTH), .LVL_W(LVL_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .approx_lvl (approx_lvl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .product    (product),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: sum of shifted multiplicand rows, each truncated below column lvl.
  function automatic int ref_mul(input int ia, input int ib, input int lvl);
    int p = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if ((ib >> i) & 1) begin
        int row = ia << i;
        p += (lvl >= 2 * WIDTH) ? 0 : ((row >> lvl) << lvl);
      end
    end
    return p % (1 << (2 * WIDTH));
  endfunction

  function automatic int ref_lat(input int ib);
`ifdef APPROX_EARLY_TERM_EN
    int msb = -1;
    for (int i = 0; i < WIDTH; i++) if ((ib >> i) & 1) msb = i;
    return msb + 1;
`else
    return WIDTH;
`endif
  endfunction

  // Issue one operation, scramble inputs while in flight, return result and edges-to-valid.
  task automatic run_op(input int ia, input int ib, input int il,
                        output int prod, output int lat);
    @(negedge clk);
    in_valid   = 1'b1;
    a          = WIDTH'(ia);
    b          = WIDTH'(ib);
    approx_lvl = LVL_W'(il);
    @(posedge clk);
    lat = 0;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      check("calc_product_zero", product, 0);
      check("calc_in_ready", in_ready, 0);
      in_valid   = 1'($urandom);
      a          = WIDTH'($urandom);
      b          = WIDTH'($urandom);
      approx_lvl = LVL_W'($urandom);
      @(posedge clk);
      lat++;
      if (lat > 40) begin
        check("out_valid_timeout", 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
    prod = int'(product);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("after_consume_in_ready", in_ready, 1);
    check("after_consume_out_valid", out_valid, 0);
    check("after_consume_product", product, 0);
  endtask

  typedef struct {
    int    a;
    int    b;
    int    lvl;
    int    exp;
    string name;
  } vec_t;

  initial begin
    vec_t vecs[8];
    int   prod;
    int   lat;

    vecs[0] = '{200, 150, 0, 30000, "v_200x150"};
    vecs[1] = '{255, 255, 0, 65025, "v_255x255"};
    vecs[2] = '{15, 15, 4, 176, "v_15x15_l4"};
    vecs[3] = '{255, 255, 8, 63232, "v_255x255_l8"};
    vecs[4] = '{255, 255, 16, 0, "v_lvl16"};
    vecs[5] = '{255, 255, 31, 0, "v_lvl31"};
    vecs[6] = '{1, 1, 1, 0, "v_1x1_l1"};
    vecs[7] = '{0, 255, 0, 0, "v_a0"};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; approx_lvl = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_product", product, 0);
    check("reset_busy", busy, 0);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].lvl, prod, lat);
      check(vecs[i].name, prod, vecs[i].exp);
      check({vecs[i].name, "_lat"}, lat, ref_lat(vecs[i].b));
      consume();
    end

    // Stall in DONE: result held, then in_valid high on the consume edge must not be accepted.
    run_op(37, 91, 3, prod, lat);
    check("hold_first", prod, ref_mul(37, 91, 3));
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_product", product, prod);
      check("hold_in_ready", in_ready, 0);
      check("hold_busy", busy, 1);
    end
    in_valid  = 1'b1;
    a         = 8'd3;
    b         = 8'd3;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("release_idle_busy", busy, 0);
    check("release_in_ready", in_ready, 1);
    check("release_out_valid", out_valid, 0);

    // Reset on the third CALC edge abandons the operation.
    in_valid = 1'b1; a = 8'd200; b = 8'd200; approx_lvl = '0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_product", product, 0);
    run_op(7, 6, 0, prod, lat);
    check("post_rst_7x6", prod, 42);
    consume();

    // Reset while in DONE.
    run_op(12, 12, 0, prod, lat);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("donerst_out_valid", out_valid, 0);
    check("donerst_busy", busy, 0);

`ifdef APPROX_EARLY_TERM_EN
    run_op(9, 1, 0, prod, lat);
    check("et_9x1", prod, 9);
    check("et_9x1_lat", lat, 1);
    consume();
    run_op(77, 0, 0, prod, lat);
    check("et_b0", prod, 0);
    check("et_b0_lat", lat, 0);
    consume();
`endif

    for (int n = 0; n < 40; n++) begin
      int ra = int'($urandom_range(0, 255));
      int rb = int'($urandom_range(0, 255));
      int rl = int'($urandom_range(0, 20));
      run_op(ra, rb, rl, prod, lat);
      check("rand_product", prod, ref_mul(ra, rb, rl));
      check("rand_lat", lat, ref_lat(rb));
      if ((n % 2) == 1) begin
        repeat (n % 4) @(negedge clk);
      end
      consume();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
